counter_run_ctrl: RTL and testbench
===================================

Name: counter_run_ctrl

Overview:
- Initiator-side controller for the team's run/num counter engine: accepts count jobs on a valid/ready request port, pulses the engine's run input with the job's target count, and waits for the engine's done pulse.
- Guards each job with a cycle timeout and returns a status response on a valid/ready response port.
- Sits between the job source (sequencer/testbench master) and the counter engine.

Parameters:
- NUM_W, 4, width of the target count (matches the engine's num input).
- TIMEOUT, 32, maximum WAIT cycles before a job is declared timed out; legal range 2..255.
- JOB_W, 8, width of the completed-job counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  job request valid.
- o_req_ready  out  1  controller can accept a job (high only in IDLE).
- i_req_num  in  NUM_W  target count of the job.
- o_run  out  1  one-cycle start pulse to the engine.
- o_num  out  NUM_W  captured target, held stable from acceptance until return to IDLE.
- i_done  in  1  engine done pulse.
- o_busy  out  1  high in ISSUE or WAIT.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  response accepted.
- o_resp_code  out  2  status: 00 OK, 01 ZERO (num==0 rejected), 10 TIMEOUT.
- o_job_cnt  out  JOB_W  count of OK completions, wraps modulo 2^JOB_W.

Behaviour:
- Reset (synchronous, active-high): state IDLE; o_num=0, o_run=0, o_resp_valid=0, o_resp_code=00, o_job_cnt=0, timeout counter=0.
  - Reset has priority in any state. Mid-job it abandons the job with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid&o_req_ready, capture i_req_num into o_num.
  - If i_req_num==0: go to RESP with code ZERO. No o_run is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - o_run=1 for exactly this one cycle; timeout counter cleared; go to WAIT.
  - If i_done is asserted while in ISSUE, it is ignored as stale.
- WAIT:
  - Timeout counter increments each cycle.
  - i_done=1: go to RESP with code OK; o_job_cnt increments by 1 (wrap 2^JOB_W-1 -> 0).
  - Otherwise, when the counter reaches TIMEOUT-1: go to RESP with code TIMEOUT.
  - If done and timeout occur in the same cycle, done wins (code OK).
- RESP:
  - o_resp_valid=1; o_resp_code and o_num held stable.
  - Leave to IDLE on the cycle i_resp_ready=1.
  - Valid must not drop before ready, and the code must not change while valid.
- Latency:
  - Request accepted at edge T -> o_run high in cycle T+1.
  - i_done sampled at edge D -> o_resp_valid high from cycle D+1.
  - Minimum back-to-back throughput: one job per (num+4) cycles with the reference engine.
- o_req_ready is low in ISSUE/WAIT/RESP; a request held valid during those states is accepted on the first IDLE cycle.
- All outputs are registered, except o_req_ready and o_busy, which are decoded from state.
- Counter widths: the timeout counter is clog2(TIMEOUT) bits and saturates, never wraps.

Decomposition:
- Shared package holds:
  - State encoding localparams IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
  - Response code constants RESP_OK=2'b00, RESP_ZERO=2'b01, RESP_TIMEOUT=2'b10.
- One natural sub-module: counter_run_timer, the loadable/clearable timeout counter with a terminal-count flag. The FSM and registers stay in the top.

Test Plan:
- Req num=5, engine model answers i_done 6 cycles after o_run -> single o_run pulse, o_num=5 held, o_resp_valid with code 00, o_job_cnt=1.
- Req num=0 -> no o_run ever, response code 01 the cycle after acceptance, o_job_cnt unchanged.
- Req num=3, engine never sends done, TIMEOUT=32 -> code 10 exactly 32 cycles after o_run; o_job_cnt unchanged.
- i_done coincides with the timeout terminal cycle -> code 00; i_done pulsed during ISSUE only -> ignored, ends in TIMEOUT.
- Backpressure: i_resp_ready held low 10 cycles -> o_resp_valid/o_resp_code stable for 10 cycles, o_req_ready stays 0 despite i_req_valid=1, next job accepted the cycle after the handshake.
- Reset asserted mid-WAIT, then 256 OK jobs -> all outputs at reset values the next cycle, no response emitted; o_job_cnt wraps 255 -> 0.

Source files
------------

// File: rtl/counter_run_ctrl_pkg.sv
// Shared definitions for the run/num counter engine controller:
// FSM state encoding and response status codes.
package counter_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] RESP_OK      = 2'b00;
  localparam logic [1:0] RESP_ZERO    = 2'b01;
  localparam logic [1:0] RESP_TIMEOUT = 2'b10;

endpackage

// File: rtl/counter_run_timer.sv
// Clearable, saturating timeout counter for counter_run_ctrl. The terminal flag
// marks the cycle whose increment brings the count to TIMEOUT-1.
module counter_run_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] count;

  // Saturates at TIMEOUT-1 instead of wrapping, so a stalled FSM never re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign terminal = enable && (count == CNT_TERM);

endmodule

// File: rtl/counter_run_ctrl.sv
// Initiator-side controller for the run/num counter engine: accepts jobs,
// pulses run with the target count, waits for done under a timeout, and responds.
module counter_run_ctrl
  import counter_run_ctrl_pkg::*;
#(
  parameter int NUM_W   = 4,
  parameter int TIMEOUT = 32,
  parameter int JOB_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic [NUM_W-1:0] i_req_num,
  output logic             o_run,
  output logic [NUM_W-1:0] o_num,
  input  logic             i_done,
  output logic             o_busy,
  output logic             o_resp_valid,
  input  logic             i_resp_ready,
  output logic [1:0]       o_resp_code,
  output logic [JOB_W-1:0] o_job_cnt
);

  state_t     state;
  state_t     next_state;
  logic       accept;
  logic       timer_clear;
  logic       timer_enable;
  logic       timer_terminal;
  logic       job_ok;
  logic [1:0] next_code;

  counter_run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .terminal (timer_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero-length job is rejected straight to RESP without touching the engine.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (i_req_valid) begin
          next_state = (i_req_num == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (i_done || timer_terminal) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (i_resp_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Done takes precedence over the terminal count, so a late done still reports OK.
  always_comb begin
    o_req_ready  = (state == IDLE);
    o_busy       = (state == ISSUE) || (state == WAIT);
    accept       = (state == IDLE) && i_req_valid;
    timer_clear  = (state == ISSUE);
    timer_enable = (state == WAIT);
    job_ok       = (state == WAIT) && i_done;
    next_code    = o_resp_code;
    if (accept && (i_req_num == '0)) begin
      next_code = RESP_ZERO;
    end else if (job_ok) begin
      next_code = RESP_OK;
    end else if ((state == WAIT) && timer_terminal) begin
      next_code = RESP_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_run        <= 1'b0;
      o_num        <= '0;
      o_resp_valid <= 1'b0;
      o_resp_code  <= RESP_OK;
      o_job_cnt    <= '0;
    end else begin
      o_run        <= (next_state == ISSUE);
      o_resp_valid <= (next_state == RESP);
      o_resp_code  <= next_code;
      if (accept) begin
        o_num <= i_req_num;
      end
      if (job_ok) begin
        o_job_cnt <= o_job_cnt + JOB_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Self-checking bench for counter_run_ctrl: directed scenarios plus randomized
// jobs checked against a cycle-offset model of the controller's contract.
module tb_counter_run_ctrl;

  localparam int NUM_W   = 4;
  localparam int TIMEOUT = 32;
  localparam int JOB_W   = 8;

  localparam logic [1:0] C_OK      = 2'b00;
  localparam logic [1:0] C_ZERO    = 2'b01;
  localparam logic [1:0] C_TIMEOUT = 2'b10;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_req_valid;
  logic             o_req_ready;
  logic [NUM_W-1:0] i_req_num;
  logic             o_run;
  logic [NUM_W-1:0] o_num;
  logic             i_done;
  logic             o_busy;
  logic             o_resp_valid;
  logic             i_resp_ready;
  logic [1:0]       o_resp_code;
  logic [JOB_W-1:0] o_job_cnt;

  int checks = 0;
  int passed = 0;
  logic [JOB_W-1:0] exp_jobs = '0;

  counter_run_ctrl #(
    .NUM_W   (NUM_W),
    .TIMEOUT (TIMEOUT),
    .JOB_W   (JOB_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_num    (i_req_num),
    .o_run        (o_run),
    .o_num        (o_num),
    .i_done       (i_done),
    .o_busy       (o_busy),
    .o_resp_valid (o_resp_valid),
    .i_resp_ready (i_resp_ready),
    .o_resp_code  (o_resp_code),
    .o_job_cnt    (o_job_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One job. done_off = cycles after the o_run cycle that i_done is pulsed (-1: never).
  // Model: run at accept+1; OK iff done lands in WAIT (1..TIMEOUT-1 after run).
  task automatic run_job(input logic [NUM_W-1:0] n, input int done_off, input int bp,
                         input logic hold_next, input logic [NUM_W-1:0] next_n);
    int t, runs, run_t, resp_t, exp_resp_t, num_bad, stable_bad;
    bit ok;
    logic [1:0] exp_code;
    ok = (n != 0) && (done_off >= 1) && (done_off <= TIMEOUT - 1);
    exp_code = (n == 0) ? C_ZERO : (ok ? C_OK : C_TIMEOUT);
    exp_resp_t = (n == 0) ? 1 : (ok ? done_off + 2 : TIMEOUT + 1);
    if (ok) exp_jobs = exp_jobs + 1'b1;

    checks++;
    if (o_req_ready !== 1'b1) $display("[TB] FAIL req_ready_idle: got %b expected 1", o_req_ready);
    else passed++;

    i_req_valid = 1'b1;
    i_req_num   = n;
    runs = 0; run_t = -1; resp_t = -1; t = 0; num_bad = 0;
    while (resp_t < 0 && t < 100) begin
      step();
      t++;
      i_req_valid = 1'b0;
      i_done = (n != 0) && (done_off >= 0) && (t == 1 + done_off);
      if (o_run === 1'b1) begin
        runs++;
        if (run_t < 0) run_t = t;
      end
      if (o_num !== n) num_bad++;
      if (o_resp_valid === 1'b1) resp_t = t;
    end
    i_done = 1'b0;

    checks++;
    if (resp_t != exp_resp_t) $display("[TB] FAIL resp_latency n=%0d: got cycle %0d expected %0d", n, resp_t, exp_resp_t);
    else passed++;
    checks++;
    if (runs != ((n != 0) ? 1 : 0)) $display("[TB] FAIL run_pulses n=%0d: got %0d expected %0d", n, runs, (n != 0) ? 1 : 0);
    else passed++;
    if (n != 0) begin
      checks++;
      if (run_t != 1) $display("[TB] FAIL run_cycle n=%0d: got %0d expected 1", n, run_t);
      else passed++;
    end
    checks++;
    if (o_resp_code !== exp_code) $display("[TB] FAIL resp_code n=%0d off=%0d: got %b expected %b", n, done_off, o_resp_code, exp_code);
    else passed++;
    checks++;
    if (num_bad != 0) $display("[TB] FAIL num_held n=%0d: got %0d bad cycles expected 0", n, num_bad);
    else passed++;
    checks++;
    if (o_job_cnt !== exp_jobs) $display("[TB] FAIL job_cnt: got %0d expected %0d", o_job_cnt, exp_jobs);
    else passed++;

    // Hold the response under backpressure, optionally with the next request pending.
    i_resp_ready = 1'b0;
    if (hold_next) begin
      i_req_valid = 1'b1;
      i_req_num   = next_n;
    end
    stable_bad = 0;
    for (int k = 0; k < bp; k++) begin
      step();
      if (o_resp_valid !== 1'b1 || o_resp_code !== exp_code || o_num !== n ||
          o_req_ready !== 1'b0 || o_busy !== 1'b0) stable_bad++;
    end
    checks++;
    if (stable_bad != 0) $display("[TB] FAIL resp_stable bp=%0d: got %0d bad cycles expected 0", bp, stable_bad);
    else passed++;

    i_resp_ready = 1'b1;
    step();
    i_resp_ready = 1'b0;
    checks++;
    if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1)
      $display("[TB] FAIL handshake_exit: got valid=%b ready=%b expected valid=0 ready=1", o_resp_valid, o_req_ready);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_req_valid = 1'b0; i_req_num = '0; i_done = 1'b0; i_resp_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({o_run, o_resp_valid, o_resp_code, o_num, o_job_cnt, o_busy, o_req_ready} !== {1'b0, 1'b0, 2'b00, 4'h0, 8'h00, 1'b0, 1'b1})
      $display("[TB] FAIL reset_values: got run=%b valid=%b code=%b num=%0d jobs=%0d busy=%b ready=%b expected 0,0,00,0,0,0,1",
               o_run, o_resp_valid, o_resp_code, o_num, o_job_cnt, o_busy, o_req_ready);
    else passed++;
    reset = 1'b0;
    exp_jobs = '0;
    step();
  endtask

  task automatic test_ok();
    run_job(4'd5, 6, 0, 1'b0, 4'd0);
  endtask

  task automatic test_zero();
    run_job(4'd0, 2, 0, 1'b0, 4'd0);
  endtask

  task automatic test_timeout();
    run_job(4'd3, -1, 0, 1'b0, 4'd0);
  endtask

  task automatic test_done_edges();
    run_job(4'd7, TIMEOUT - 1, 0, 1'b0, 4'd0);
    run_job(4'd2, 0, 0, 1'b0, 4'd0);
    run_job(4'd9, TIMEOUT, 0, 1'b0, 4'd0);
  endtask

  task automatic test_back_to_back();
    run_job(4'd6, 3, 10, 1'b1, 4'd4);
    run_job(4'd4, 2, 0, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    i_req_valid = 1'b1;
    i_req_num   = 4'd4;
    step();
    i_req_valid = 1'b0;
    repeat (5) step();
    checks++;
    if (o_busy !== 1'b1) $display("[TB] FAIL busy_in_wait: got %b expected 1", o_busy);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_jobs = '0;
    checks++;
    if ({o_run, o_resp_valid, o_num, o_job_cnt, o_busy, o_req_ready} !== {1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1})
      $display("[TB] FAIL mid_reset: got run=%b valid=%b num=%0d jobs=%0d busy=%b ready=%b expected 0,0,0,0,0,1",
               o_run, o_resp_valid, o_num, o_job_cnt, o_busy, o_req_ready);
    else passed++;
    bad = 0;
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    for (int k = 0; k < TIMEOUT + 8; k++) begin
      if (o_resp_valid !== 1'b0 || o_run !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) $display("[TB] FAIL no_resp_after_reset: got %0d bad cycles expected 0", bad);
    else passed++;
  endtask

  task automatic test_wrap();
    for (int j = 0; j < 256; j++) begin
      run_job(4'($urandom_range(15, 1)), int'($urandom_range(8, 1)), int'($urandom_range(2, 0)), 1'b0, 4'd0);
    end
    checks++;
    if (o_job_cnt !== 8'd0) $display("[TB] FAIL job_cnt_wrap: got %0d expected 0", o_job_cnt);
    else passed++;
  endtask

  task automatic test_random();
    int r;
    for (int j = 0; j < 40; j++) begin
      r = int'($urandom_range(TIMEOUT + 6, 0));
      if (r > TIMEOUT + 3) r = -1;
      run_job(4'($urandom_range(15, 0)), r, int'($urandom_range(3, 0)), 1'b0, 4'd0);
    end
  endtask

  initial begin
    test_reset();
    test_ok();
    test_zero();
    test_timeout();
    test_done_edges();
    test_back_to_back();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
